cache_bank_request_scheduler: RTL and testbench

Parametrised successor of the per-router cache access arbiter. Accepts read/write requests from NUM_PORTS router ports with a valid/ready handshake and holds them in a shared in-order request queue of QUEUE_DEPTH entries. Each cycle it issues up to two requests to the dual-channel cache bank (channels A and B) and routes read data back to the requesting port. Arbitration is round-robin, hazard-safe and free of starvation.

---
 rtl/cache_bank_request_scheduler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_cache_bank_request_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bank_request_scheduler.sv
// cache_bank_request_scheduler
// Shared in-order request queue in front of a dual-channel cache bank.
// Router ports are admitted round-robin into the queue. The two oldest
// entries are issued each cycle on channels A and B when that is hazard-safe.
// Read data is returned to the originating port two edges after acceptance.
module cache_bank_request_scheduler #(
    parameter int NUM_PORTS                = 4,
    parameter int DATA_WIDTH               = 32,
    parameter int CACHE_BANK_ADDRESS_WIDTH = 8,
    parameter int NETWORK_ADDRESS_WIDTH    = 4,
    parameter int QUEUE_DEPTH              = 8
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_PORTS-1:0]                         req_valid,
    input  logic [NUM_PORTS-1:0]                         req_write,
    input  logic [NUM_PORTS*CACHE_BANK_ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]              req_data,
    input  logic [NUM_PORTS*NETWORK_ADDRESS_WIDTH-1:0]   req_src,
    output logic [NUM_PORTS-1:0]                         req_ready,
    output logic [NUM_PORTS-1:0]                         resp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]              resp_data,
    output logic [NUM_PORTS*NETWORK_ADDRESS_WIDTH-1:0]   resp_src,
    output logic [CACHE_BANK_ADDRESS_WIDTH-1:0]          mem_addr_a,
    output logic [CACHE_BANK_ADDRESS_WIDTH-1:0]          mem_addr_b,
    output logic [DATA_WIDTH-1:0]                        mem_wdata_a,
    output logic [DATA_WIDTH-1:0]                        mem_wdata_b,
    output logic                                         mem_we_n_a,
    output logic                                         mem_we_n_b,
    input  logic [DATA_WIDTH-1:0]                        mem_rdata_a,
    input  logic [DATA_WIDTH-1:0]                        mem_rdata_b,
    output logic [$clog2(QUEUE_DEPTH):0]                 queue_count
);

    localparam int AW     = CACHE_BANK_ADDRESS_WIDTH;
    localparam int DW     = DATA_WIDTH;
    localparam int NW     = NETWORK_ADDRESS_WIDTH;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    // Queue storage: one record per accepted request.
    logic [AW-1:0]     qAddr  [QUEUE_DEPTH];
    logic [DW-1:0]     qData  [QUEUE_DEPTH];
    logic              qWrite [QUEUE_DEPTH];
    logic [PORT_W-1:0] qPort  [QUEUE_DEPTH];
    logic [NW-1:0]     qSrc   [QUEUE_DEPTH];

    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [PTR_W-1:0]  headNext;
    logic [PORT_W-1:0] rrPtr;
    logic [PORT_W-1:0] rrNext;

    // Issue decision for the current cycle.
    logic              issueA;
    logic              issueB;
    logic              sameAddr;
    logic              anyWrite;
    logic              samePortReads;
    logic [CNT_W-1:0]  issueNum;

    // Acceptance bookkeeping.
    logic [CNT_W-1:0]  freeSlots;
    logic [PORT_W-1:0] portOffset [NUM_PORTS];
    logic [CNT_W-1:0]  portRank   [NUM_PORTS];
    logic [PTR_W-1:0]  slot       [NUM_PORTS];
    logic [NUM_PORTS-1:0] acceptMask;
    logic [CNT_W-1:0]  acceptNum;

    // Read tags for the entries presented to the bank last edge.
    logic              tagValidA;
    logic              tagValidB;
    logic [PORT_W-1:0] tagPortA;
    logic [PORT_W-1:0] tagPortB;
    logic [NW-1:0]     tagSrcA;
    logic [NW-1:0]     tagSrcB;
    logic [NUM_PORTS-1:0] respFromB;

    // Position of a port in the rotated order that starts at the rr pointer.
    function automatic logic [PORT_W-1:0] rotOffset(input int port, input logic [PORT_W-1:0] start);
        int diff;
        diff = port - int'(start);
        if (diff < 0) begin
            diff = diff + NUM_PORTS;
        end
        return PORT_W'(diff);
    endfunction

    // Choose which of the two oldest entries can be issued this cycle.
    always_comb begin
        headNext      = headPtr + PTR_W'(1);
        issueA        = (queue_count != CNT_W'(0));
        sameAddr      = (qAddr[headPtr] == qAddr[headNext]);
        anyWrite      = qWrite[headPtr] | qWrite[headNext];
        samePortReads = !qWrite[headPtr] && !qWrite[headNext] &&
                        (qPort[headPtr] == qPort[headNext]);
        if (queue_count >= CNT_W'(2)) begin
            issueB = !(sameAddr && anyWrite) && !samePortReads;
        end else begin
            issueB = 1'b0;
        end
        issueNum = CNT_W'(issueA) + CNT_W'(issueB);
    end

    // Rank valid ports in rotated order; a port is ready if its rank fits in the free space.
    always_comb begin
        freeSlots = DEPTH_C - queue_count + issueNum;
        for (int i = 0; i < NUM_PORTS; i++) begin
            portOffset[i] = rotOffset(i, rrPtr);
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            portRank[i] = CNT_W'(0);
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (req_valid[j] && (portOffset[j] < portOffset[i])) begin
                    portRank[i] = portRank[i] + CNT_W'(1);
                end else begin
                    portRank[i] = portRank[i];
                end
            end
            req_ready[i] = (portRank[i] < freeSlots);
        end
    end

    // Work out queue slots for granted ports and where the rr pointer moves next.
    always_comb begin
        acceptMask = req_valid & req_ready;
        acceptNum  = CNT_W'(0);
        rrNext     = rrPtr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            slot[i] = tailPtr + portRank[i][PTR_W-1:0];
            if (acceptMask[i]) begin
                acceptNum = acceptNum + CNT_W'(1);
            end else begin
                acceptNum = acceptNum;
            end
            // Valid ports have contiguous ranks, so the first refused one sits at rank == free.
            if (req_valid[i] && !req_ready[i] && (portRank[i] == freeSlots)) begin
                rrNext = PORT_W'(i);
            end else begin
                rrNext = rrNext;
            end
        end
    end

    // Queue storage, pointers, occupancy and arbitration pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr     <= PTR_W'(0);
            tailPtr     <= PTR_W'(0);
            queue_count <= CNT_W'(0);
            rrPtr       <= PORT_W'(0);
            for (int k = 0; k < QUEUE_DEPTH; k++) begin
                qAddr[k]  <= AW'(0);
                qData[k]  <= DW'(0);
                qWrite[k] <= 1'b0;
                qPort[k]  <= PORT_W'(0);
                qSrc[k]   <= NW'(0);
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (acceptMask[i]) begin
                    qAddr[slot[i]]  <= req_addr[i*AW +: AW];
                    qData[slot[i]]  <= req_data[i*DW +: DW];
                    qWrite[slot[i]] <= req_write[i];
                    qPort[slot[i]]  <= PORT_W'(i);
                    qSrc[slot[i]]   <= req_src[i*NW +: NW];
                end
            end
            headPtr     <= headPtr + issueNum[PTR_W-1:0];
            tailPtr     <= tailPtr + acceptNum[PTR_W-1:0];
            queue_count <= queue_count + acceptNum - issueNum;
            rrPtr       <= rrNext;
        end
    end

    // Present up to two entries to the bank and record tags for the reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr_a  <= AW'(0);
            mem_addr_b  <= AW'(0);
            mem_wdata_a <= DW'(0);
            mem_wdata_b <= DW'(0);
            mem_we_n_a  <= 1'b1;
            mem_we_n_b  <= 1'b1;
            tagValidA   <= 1'b0;
            tagValidB   <= 1'b0;
            tagPortA    <= PORT_W'(0);
            tagPortB    <= PORT_W'(0);
            tagSrcA     <= NW'(0);
            tagSrcB     <= NW'(0);
        end else begin
            if (issueA) begin
                mem_addr_a  <= qAddr[headPtr];
                mem_wdata_a <= qData[headPtr];
                mem_we_n_a  <= !qWrite[headPtr];
                tagValidA   <= !qWrite[headPtr];
                tagPortA    <= qPort[headPtr];
                tagSrcA     <= qSrc[headPtr];
            end else begin
                mem_we_n_a  <= 1'b1;
                tagValidA   <= 1'b0;
            end
            if (issueB) begin
                mem_addr_b  <= qAddr[headNext];
                mem_wdata_b <= qData[headNext];
                mem_we_n_b  <= !qWrite[headNext];
                tagValidB   <= !qWrite[headNext];
                tagPortB    <= qPort[headNext];
                tagSrcB     <= qSrc[headNext];
            end else begin
                mem_we_n_b  <= 1'b1;
                tagValidB   <= 1'b0;
            end
        end
    end

    // Turn last cycle's read tags into per-port response strobes; A and B never share a port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= {NUM_PORTS{1'b0}};
            resp_src   <= {(NUM_PORTS*NW){1'b0}};
            respFromB  <= {NUM_PORTS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (tagValidA && (tagPortA == PORT_W'(i))) begin
                    resp_valid[i]         <= 1'b1;
                    resp_src[i*NW +: NW]  <= tagSrcA;
                    respFromB[i]          <= 1'b0;
                end else if (tagValidB && (tagPortB == PORT_W'(i))) begin
                    resp_valid[i]         <= 1'b1;
                    resp_src[i*NW +: NW]  <= tagSrcB;
                    respFromB[i]          <= 1'b1;
                end else begin
                    resp_valid[i]         <= 1'b0;
                    resp_src[i*NW +: NW]  <= NW'(0);
                    respFromB[i]          <= 1'b0;
                end
            end
        end
    end

    // Bank read data arrives the cycle the strobe is up; steer it to the owning port.
    always_comb begin
        resp_data = {(NUM_PORTS*DW){1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (resp_valid[i]) begin
                if (respFromB[i]) begin
                    resp_data[i*DW +: DW] = mem_rdata_b;
                end else begin
                    resp_data[i*DW +: DW] = mem_rdata_a;
                end
            end else begin
                resp_data[i*DW +: DW] = DW'(0);
            end
        end
    end

endmodule

// File: tb/tb_cache_bank_request_scheduler.sv
// Directed self-checking bench for cache_bank_request_scheduler with a
// synchronous dual-port bank model.
module tb_cache_bank_request_scheduler;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NW = 4;
    localparam int QD = 8;

    logic              clk;
    logic              reset;
    logic [NP-1:0]     reqValid;
    logic [NP-1:0]     reqWrite;
    logic [NP*AW-1:0]  reqAddr;
    logic [NP*DW-1:0]  reqData;
    logic [NP*NW-1:0]  reqSrc;
    logic [NP-1:0]     reqReady;
    logic [NP-1:0]     respValid;
    logic [NP*DW-1:0]  respData;
    logic [NP*NW-1:0]  respSrc;
    logic [AW-1:0]     memAddrA;
    logic [AW-1:0]     memAddrB;
    logic [DW-1:0]     memWdataA;
    logic [DW-1:0]     memWdataB;
    logic              memWeNA;
    logic              memWeNB;
    logic [DW-1:0]     memRdataA;
    logic [DW-1:0]     memRdataB;
    logic [3:0]        queueCount;

    logic [DW-1:0]     bank [256];
    logic              loadEn;
    logic [AW-1:0]     loadAddr;
    logic [DW-1:0]     loadData;

    int compared;
    int mismatched;

    cache_bank_request_scheduler #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .CACHE_BANK_ADDRESS_WIDTH(AW),
        .NETWORK_ADDRESS_WIDTH(NW), .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(reqValid), .req_write(reqWrite), .req_addr(reqAddr),
        .req_data(reqData), .req_src(reqSrc), .req_ready(reqReady),
        .resp_valid(respValid), .resp_data(respData), .resp_src(respSrc),
        .mem_addr_a(memAddrA), .mem_addr_b(memAddrB),
        .mem_wdata_a(memWdataA), .mem_wdata_b(memWdataB),
        .mem_we_n_a(memWeNA), .mem_we_n_b(memWeNB),
        .mem_rdata_a(memRdataA), .mem_rdata_b(memRdataB),
        .queue_count(queueCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: read-first synchronous RAM with a preload port.
    always @(posedge clk) begin
        memRdataA <= bank[memAddrA];
        memRdataB <= bank[memAddrB];
        if (loadEn) bank[loadAddr] <= loadData;
        if (!memWeNA) bank[memAddrA] <= memWdataA;
        if (!memWeNB) bank[memAddrB] <= memWdataB;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearReq;
        reqValid = 4'b0000;
        reqWrite = 4'b0000;
        reqAddr  = '0;
        reqData  = '0;
        reqSrc   = '0;
    endtask

    task automatic setReq(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NW-1:0] s);
        reqValid[p]         = 1'b1;
        reqWrite[p]         = w;
        reqAddr[p*AW +: AW] = a;
        reqData[p*DW +: DW] = d;
        reqSrc[p*NW +: NW]  = s;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        clearReq();
        for (int p = 0; p < NP; p++) setReq(p, 1'b1, 8'h80 + 8'(p), 32'h100 + 32'(p), 4'(p));
        loadEn = 1'b1; loadAddr = 8'h10; loadData = 32'hDEADBEEF;
        tick();
        loadEn = 1'b0;
        tick();
        compared++; if (memWeNA !== 1'b1) begin mismatched++; $display("FAIL rst_we_n_a: got %b expected 1", memWeNA); end
        compared++; if (memWeNB !== 1'b1) begin mismatched++; $display("FAIL rst_we_n_b: got %b expected 1", memWeNB); end
        compared++; if (respValid !== 4'b0000) begin mismatched++; $display("FAIL rst_resp_valid: got %b expected 0000", respValid); end
        compared++; if (queueCount !== 4'd0) begin mismatched++; $display("FAIL rst_count: got %0d expected 0", queueCount); end
        compared++; if (memAddrA !== 8'h00) begin mismatched++; $display("FAIL rst_addr_a: got %h expected 00", memAddrA); end
        compared++; if (reqReady !== 4'b1111) begin mismatched++; $display("FAIL rst_ready: got %b expected 1111", reqReady); end
        reset = 1'b1;
        tick();
        clearReq();
        compared++; if (queueCount !== 4'd4) begin mismatched++; $display("FAIL rel_count: got %0d expected 4", queueCount); end
        tick();
        compared++; if (memAddrA !== 8'h80 || memAddrB !== 8'h81) begin mismatched++; $display("FAIL rel_pair: got %h/%h expected 80/81", memAddrA, memAddrB); end
        compared++; if (memWeNA !== 1'b0 || memWeNB !== 1'b0) begin mismatched++; $display("FAIL rel_we: got %b/%b expected 0/0", memWeNA, memWeNB); end
        tick();
        tick();
        compared++; if (queueCount !== 4'd0) begin mismatched++; $display("FAIL rel_drain: got %0d expected 0", queueCount); end
    endtask

    task automatic test_single_read;
        setReq(2, 1'b0, 8'h10, 32'h0, 4'hA);
        compared++; if (reqReady[2] !== 1'b1) begin mismatched++; $display("FAIL rd_ready: got %b expected 1", reqReady[2]); end
        tick();
        clearReq();
        compared++; if (queueCount !== 4'd1) begin mismatched++; $display("FAIL rd_count: got %0d expected 1", queueCount); end
        tick();
        compared++; if (memAddrA !== 8'h10 || memWeNA !== 1'b1 || memWeNB !== 1'b1) begin mismatched++; $display("FAIL rd_issue: got addr %h we %b/%b expected 10 1/1", memAddrA, memWeNA, memWeNB); end
        compared++; if (respValid !== 4'b0000) begin mismatched++; $display("FAIL rd_early: got %b expected 0000", respValid); end
        tick();
        compared++; if (respValid !== 4'b0100) begin mismatched++; $display("FAIL rd_valid: got %b expected 0100", respValid); end
        compared++; if (respData[2*DW +: DW] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL rd_data: got %h expected deadbeef", respData[2*DW +: DW]); end
        compared++; if (respSrc[2*NW +: NW] !== 4'hA) begin mismatched++; $display("FAIL rd_src: got %h expected a", respSrc[2*NW +: NW]); end
        compared++; if (respData[0 +: DW] !== 32'h0) begin mismatched++; $display("FAIL rd_idle_data: got %h expected 0", respData[0 +: DW]); end
        tick();
        compared++; if (respValid !== 4'b0000) begin mismatched++; $display("FAIL rd_pulse: got %b expected 0000", respValid); end
    endtask

    task automatic test_four_writes;
        for (int p = 0; p < NP; p++) setReq(p, 1'b1, 8'h01 + 8'(p), 32'hA1 + 32'(p), 4'(p));
        tick();
        clearReq();
        compared++; if (queueCount !== 4'd4) begin mismatched++; $display("FAIL wr_count: got %0d expected 4", queueCount); end
        tick();
        compared++; if (memAddrA !== 8'h01 || memAddrB !== 8'h02) begin mismatched++; $display("FAIL wr_pair1_addr: got %h/%h expected 01/02", memAddrA, memAddrB); end
        compared++; if (memWdataA !== 32'hA1 || memWdataB !== 32'hA2) begin mismatched++; $display("FAIL wr_pair1_data: got %h/%h expected a1/a2", memWdataA, memWdataB); end
        compared++; if (memWeNA !== 1'b0 || memWeNB !== 1'b0) begin mismatched++; $display("FAIL wr_pair1_we: got %b/%b expected 0/0", memWeNA, memWeNB); end
        tick();
        compared++; if (memAddrA !== 8'h03 || memAddrB !== 8'h04 || memWdataB !== 32'hA4) begin mismatched++; $display("FAIL wr_pair2: got %h/%h %h expected 03/04 a4", memAddrA, memAddrB, memWdataB); end
        compared++; if (queueCount !== 4'd0) begin mismatched++; $display("FAIL wr_drain: got %0d expected 0", queueCount); end
        tick();
        compared++; if (memWeNA !== 1'b1 || memWeNB !== 1'b1 || respValid !== 4'b0000) begin mismatched++; $display("FAIL wr_idle: got we %b/%b resp %b expected 1/1 0000", memWeNA, memWeNB, respValid); end
    endtask

    task automatic test_hazard;
        setReq(0, 1'b1, 8'h20, 32'h55, 4'h0);
        setReq(1, 1'b0, 8'h20, 32'h0, 4'h3);
        tick();
        clearReq();
        compared++; if (queueCount !== 4'd2) begin mismatched++; $display("FAIL hz_count: got %0d expected 2", queueCount); end
        tick();
        compared++; if (memWeNA !== 1'b0 || memAddrA !== 8'h20 || memWdataA !== 32'h55) begin mismatched++; $display("FAIL hz_write: got we %b addr %h data %h expected 0 20 55", memWeNA, memAddrA, memWdataA); end
        compared++; if (memWeNB !== 1'b1 || memAddrB !== 8'h04) begin mismatched++; $display("FAIL hz_b_idle: got we %b addr %h expected 1 04", memWeNB, memAddrB); end
        tick();
        compared++; if (memWeNA !== 1'b1 || memAddrA !== 8'h20 || queueCount !== 4'd0) begin mismatched++; $display("FAIL hz_read: got we %b addr %h cnt %0d expected 1 20 0", memWeNA, memAddrA, queueCount); end
        tick();
        compared++; if (respValid !== 4'b0010 || respData[1*DW +: DW] !== 32'h55) begin mismatched++; $display("FAIL hz_resp: got %b %h expected 0010 55", respValid, respData[1*DW +: DW]); end
        compared++; if (respSrc[1*NW +: NW] !== 4'h3) begin mismatched++; $display("FAIL hz_src: got %h expected 3", respSrc[1*NW +: NW]); end
        tick();
    endtask

    task automatic test_dual_read;
        setReq(0, 1'b0, 8'h01, 32'h0, 4'h1);
        setReq(3, 1'b0, 8'h03, 32'h0, 4'h7);
        tick();
        clearReq();
        tick();
        compared++; if (memAddrA !== 8'h01 || memAddrB !== 8'h03 || memWeNA !== 1'b1 || memWeNB !== 1'b1) begin mismatched++; $display("FAIL dr_issue: got %h/%h we %b/%b expected 01/03 1/1", memAddrA, memAddrB, memWeNA, memWeNB); end
        tick();
        compared++; if (respValid !== 4'b1001) begin mismatched++; $display("FAIL dr_valid: got %b expected 1001", respValid); end
        compared++; if (respData[0 +: DW] !== 32'hA1 || respData[3*DW +: DW] !== 32'hA3) begin mismatched++; $display("FAIL dr_data: got %h/%h expected a1/a3", respData[0 +: DW], respData[3*DW +: DW]); end
        compared++; if (respSrc[3*NW +: NW] !== 4'h7 || respSrc[0 +: NW] !== 4'h1) begin mismatched++; $display("FAIL dr_src: got %h/%h expected 1/7", respSrc[0 +: NW], respSrc[3*NW +: NW]); end
        tick();
    endtask

    task automatic test_back_to_back;
        setReq(0, 1'b1, 8'h30, 32'h77, 4'h0);
        setReq(1, 1'b0, 8'h30, 32'h0, 4'h5);
        tick();
        clearReq();
        compared++; if (queueCount !== 4'd2) begin mismatched++; $display("FAIL bb_count1: got %0d expected 2", queueCount); end
        setReq(1, 1'b0, 8'h02, 32'h0, 4'h6);
        tick();
        clearReq();
        compared++; if (memWeNA !== 1'b0 || memAddrA !== 8'h30 || memWeNB !== 1'b1 || queueCount !== 4'd2) begin mismatched++; $display("FAIL bb_write: got we %b/%b addr %h cnt %0d expected 0/1 30 2", memWeNA, memWeNB, memAddrA, queueCount); end
        tick();
        compared++; if (memWeNA !== 1'b1 || memAddrA !== 8'h30 || memWeNB !== 1'b1 || queueCount !== 4'd1) begin mismatched++; $display("FAIL bb_same_port: got we %b/%b addr %h cnt %0d expected 1/1 30 1", memWeNA, memWeNB, memAddrA, queueCount); end
        tick();
        compared++; if (memAddrA !== 8'h02 || queueCount !== 4'd0) begin mismatched++; $display("FAIL bb_second: got addr %h cnt %0d expected 02 0", memAddrA, queueCount); end
        compared++; if (respValid !== 4'b0010 || respData[1*DW +: DW] !== 32'h77 || respSrc[1*NW +: NW] !== 4'h5) begin mismatched++; $display("FAIL bb_resp1: got %b %h %h expected 0010 77 5", respValid, respData[1*DW +: DW], respSrc[1*NW +: NW]); end
        tick();
        compared++; if (respValid !== 4'b0010 || respData[1*DW +: DW] !== 32'hA2 || respSrc[1*NW +: NW] !== 4'h6) begin mismatched++; $display("FAIL bb_resp2: got %b %h %h expected 0010 a2 6", respValid, respData[1*DW +: DW], respSrc[1*NW +: NW]); end
        tick();
        compared++; if (respValid !== 4'b0000) begin mismatched++; $display("FAIL bb_end: got %b expected 0000", respValid); end
    endtask

    task automatic test_full_queue;
        logic [3:0] expReady [6];
        logic [3:0] expCount [6];
        logic [7:0] expAddrA [6];
        int lateAccepts [4];
        int expLate [4];
        expReady = '{4'b1111, 4'b1111, 4'b1111, 4'b0011, 4'b1100, 4'b0011};
        expCount = '{4'd4, 4'd6, 4'd8, 4'd8, 4'd8, 4'd8};
        expAddrA = '{8'h00, 8'h40, 8'h42, 8'h40, 8'h42, 8'h40};
        expLate  = '{2, 2, 1, 1};
        lateAccepts = '{0, 0, 0, 0};
        for (int p = 0; p < NP; p++) setReq(p, 1'b1, 8'h40 + 8'(p), 32'h200 + 32'(p), 4'(p));
        for (int k = 0; k < 6; k++) begin
            compared++; if (reqReady !== expReady[k]) begin mismatched++; $display("FAIL fq_ready[%0d]: got %b expected %b", k, reqReady, expReady[k]); end
            if (k >= 3) begin
                for (int p = 0; p < NP; p++) if (reqReady[p]) lateAccepts[p]++;
            end
            tick();
            compared++; if (queueCount !== expCount[k]) begin mismatched++; $display("FAIL fq_count[%0d]: got %0d expected %0d", k, queueCount, expCount[k]); end
            if (k >= 1) begin
                compared++; if (memAddrA !== expAddrA[k] || memAddrB !== expAddrA[k] + 8'h01) begin mismatched++; $display("FAIL fq_issue[%0d]: got %h/%h expected %h/%h", k, memAddrA, memAddrB, expAddrA[k], expAddrA[k] + 8'h01); end
            end
        end
        for (int p = 0; p < NP; p++) begin
            compared++; if (lateAccepts[p] != expLate[p]) begin mismatched++; $display("FAIL fq_fair[%0d]: got %0d expected %0d", p, lateAccepts[p], expLate[p]); end
        end
        clearReq();
        for (int k = 0; k < 4; k++) tick();
        compared++; if (queueCount !== 4'd0) begin mismatched++; $display("FAIL fq_drain: got %0d expected 0", queueCount); end
        tick();
    endtask

    task automatic test_reset_mid;
        for (int p = 0; p < NP; p++) setReq(p, 1'b0, 8'h01 + 8'(p), 32'h0, 4'h8 + 4'(p));
        tick();
        compared++; if (queueCount !== 4'd4) begin mismatched++; $display("FAIL rm_count4: got %0d expected 4", queueCount); end
        reqValid[3] = 1'b0;
        tick();
        clearReq();
        compared++; if (queueCount !== 4'd5) begin mismatched++; $display("FAIL rm_count5: got %0d expected 5", queueCount); end
        reset = 1'b0;
        #1;
        compared++; if (queueCount !== 4'd0) begin mismatched++; $display("FAIL rm_async_count: got %0d expected 0", queueCount); end
        compared++; if (memWeNA !== 1'b1 || memWeNB !== 1'b1 || memAddrA !== 8'h00) begin mismatched++; $display("FAIL rm_async_mem: got we %b/%b addr %h expected 1/1 00", memWeNA, memWeNB, memAddrA); end
        tick();
        compared++; if (respValid !== 4'b0000) begin mismatched++; $display("FAIL rm_in_reset: got %b expected 0000", respValid); end
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++; if (respValid !== 4'b0000 || queueCount !== 4'd0) begin mismatched++; $display("FAIL rm_after[%0d]: got resp %b cnt %0d expected 0000 0", k, respValid, queueCount); end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        loadEn     = 1'b0;
        loadAddr   = 8'h00;
        loadData   = 32'h0;
        clearReq();
        test_reset();
        test_single_read();
        test_four_writes();
        test_hazard();
        test_dual_read();
        test_back_to_back();
        test_full_queue();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
